hilo_div_ctrl: RTL and testbench



---
 rtl/hilo_div_ctrl_pkg.sv | 5 +
 rtl/hilo_div_ctrl.sv | 80 ++++++++
 tb/tb_hilo_div_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/hilo_div_ctrl_pkg.sv
// hilo_div_ctrl_pkg: FSM states and constants shared by the divide/HI-LO stage
package hilo_div_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, START, WAIT, FIX} state_t;
    localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
endpackage

// File: rtl/hilo_div_ctrl.sv
// hilo_div_ctrl: issues DIV/DIVU to an unsigned iterative core, sign-corrects and writes HI/LO
module hilo_div_ctrl
    import hilo_div_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        op_valid,
    input  logic        op_signed,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        mthi_we,
    input  logic        mtlo_we,
    input  logic [31:0] mt_data,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    output logic        div_start,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    input  logic        div_busy
);
    state_t      state, next;
    logic        sign_q, sign_r, div0, busy_seen;
    logic [31:0] rs_hold;

    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic n);
        return n ? -v : v;
    endfunction

    always_comb begin
        next = state == IDLE  ? (op_valid ? (rt_val != '0 ? START : FIX) : IDLE)
             : state == START ? WAIT
             : state == WAIT  ? (!div_busy && busy_seen ? FIX : WAIT)
             : IDLE;
        stall     = (state == IDLE && op_valid) || state == START || state == WAIT;
        div_start = state == START;
    end

    always_ff @(posedge clock or posedge reset)
        if (reset) state <= IDLE;
        else       state <= next;

    // 0x80000000 / -1 needs no special case: both magnitude and negation wrap
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hi           <= '0;
            lo           <= '0;
            div_dividend <= '0;
            div_divisor  <= '0;
            sign_q       <= 1'b0;
            sign_r       <= 1'b0;
            div0         <= 1'b0;
            busy_seen    <= 1'b0;
            rs_hold      <= '0;
        end else begin
            if (state == IDLE) begin
                if (mthi_we) hi <= mt_data;
                if (mtlo_we) lo <= mt_data;
                if (op_valid) begin
                    sign_q  <= op_signed & (rs_val[31] ^ rt_val[31]);
                    sign_r  <= op_signed & rs_val[31];
                    div0    <= rt_val == '0;
                    rs_hold <= rs_val;
                    if (rt_val != '0) begin
                        div_dividend <= neg_if(rs_val, op_signed & rs_val[31]);
                        div_divisor  <= neg_if(rt_val, op_signed & rt_val[31]);
                    end
                end
            end
            if (state == START) busy_seen <= 1'b0;
            if (state == WAIT && div_busy) busy_seen <= 1'b1;
            if (state == FIX) begin
                lo <= div0 ? DIV0_QUOTIENT : neg_if(div_q, sign_q);
                hi <= div0 ? rs_hold : neg_if(div_r, sign_r);
            end
        end
    end
endmodule

// File: tb/tb_hilo_div_ctrl.sv
// tb_hilo_div_ctrl: directed checks of hilo_div_ctrl against a 32-cycle behavioural divider core
module tb_hilo_div_ctrl;
    logic        clock = 0, reset = 1;
    logic        op_valid = 0, op_signed = 0, mthi_we = 0, mtlo_we = 0;
    logic [31:0] rs_val = 0, rt_val = 0, mt_data = 0;
    logic        stall, div_start, div_busy;
    logic [31:0] hi, lo, div_dividend, div_divisor, div_q, div_r;
    logic [5:0]  cnt;
    int checks = 0, errors = 0;

    hilo_div_ctrl dut (
        .clock(clock), .reset(reset), .op_valid(op_valid), .op_signed(op_signed),
        .rs_val(rs_val), .rt_val(rt_val), .mthi_we(mthi_we), .mtlo_we(mtlo_we),
        .mt_data(mt_data), .stall(stall), .hi(hi), .lo(lo),
        .div_dividend(div_dividend), .div_divisor(div_divisor), .div_start(div_start),
        .div_q(div_q), .div_r(div_r), .div_busy(div_busy)
    );

    always #5 clock = ~clock;

    // core model: busy for 32 cycles after the start edge, results held afterwards
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_busy <= 0; cnt <= 0; div_q <= 0; div_r <= 0;
        end else if (div_start) begin
            div_busy <= 1; cnt <= 32;
            div_q <= div_dividend / div_divisor;
            div_r <= div_dividend % div_divisor;
        end else if (div_busy) begin
            cnt <= cnt - 1;
            if (cnt == 1) div_busy <= 0;
        end
    end

    task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                           input int mt_at, input int rst_at, input logic imm,
                           output int ns, output int nst);
        logic done;
        done = 0; ns = 0; nst = 0;
        if (!imm) @(negedge clock);
        op_valid = 1; op_signed = sg; rs_val = a; rt_val = b;
        for (int c = 0; c < 100; c++) begin
            mtlo_we = (c == mt_at); mt_data = 32'hDEAD_BEEF;
            if (c == rst_at) begin
                reset = 1; op_valid = 0; mtlo_we = 0; done = 1;
                break;
            end
            #1;
            ns += int'(stall); nst += int'(div_start);
            if (!stall) begin
                op_valid = 0; done = 1;
                break;
            end
            @(negedge clock);
        end
        mtlo_we = 0; op_valid = 0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL timeout: stall still %b after 100 cycles, required 0", stall);
        end
        @(negedge clock);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks += 6;
        if (hi !== 0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
        if (lo !== 0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
        if (stall !== 0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        if (div_start !== 0) begin errors++; $display("FAIL reset_start: got %b want 0", div_start); end
        if (div_dividend !== 0) begin errors++; $display("FAIL reset_dividend: got %h want 0", div_dividend); end
        if (div_divisor !== 0) begin errors++; $display("FAIL reset_divisor: got %h want 0", div_divisor); end
        @(negedge clock); reset = 0;
        @(negedge clock);
    endtask

    task automatic test_divu();
        int ns, nst;
        run_div(0, 100, 7, -1, -1, 0, ns, nst);
        checks += 6;
        if (lo !== 14) begin errors++; $display("FAIL divu_lo: got %h want e", lo); end
        if (hi !== 2) begin errors++; $display("FAIL divu_hi: got %h want 2", hi); end
        if (ns !== 35) begin errors++; $display("FAIL divu_stall_cycles: got %0d want 35", ns); end
        if (nst !== 1) begin errors++; $display("FAIL divu_start_pulses: got %0d want 1", nst); end
        if (div_dividend !== 100) begin errors++; $display("FAIL divu_dividend: got %h want 64", div_dividend); end
        if (div_divisor !== 7) begin errors++; $display("FAIL divu_divisor: got %h want 7", div_divisor); end
    endtask

    task automatic test_signed();
        int ns, nst;
        run_div(1, 32'hFFFF_FF9C, 7, -1, -1, 0, ns, nst);
        checks += 3;
        if (lo !== 32'hFFFF_FFF2) begin errors++; $display("FAIL negdiv_lo: got %h want fffffff2", lo); end
        if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL negdiv_hi: got %h want fffffffe", hi); end
        if (div_dividend !== 100) begin errors++; $display("FAIL negdiv_mag: got %h want 64", div_dividend); end
        run_div(1, 100, 32'hFFFF_FFF9, -1, -1, 0, ns, nst);
        checks += 3;
        if (lo !== 32'hFFFF_FFF2) begin errors++; $display("FAIL negdivisor_lo: got %h want fffffff2", lo); end
        if (hi !== 2) begin errors++; $display("FAIL negdivisor_hi: got %h want 2", hi); end
        if (div_divisor !== 7) begin errors++; $display("FAIL negdivisor_mag: got %h want 7", div_divisor); end
    endtask

    task automatic test_edges();
        int ns, nst;
        run_div(1, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, 0, ns, nst);
        checks += 2;
        if (lo !== 32'h8000_0000) begin errors++; $display("FAIL ovf_lo: got %h want 80000000", lo); end
        if (hi !== 0) begin errors++; $display("FAIL ovf_hi: got %h want 0", hi); end
        run_div(0, 32'hFFFF_FFFF, 1, -1, -1, 0, ns, nst);
        checks += 2;
        if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL umax_lo: got %h want ffffffff", lo); end
        if (hi !== 0) begin errors++; $display("FAIL umax_hi: got %h want 0", hi); end
    endtask

    task automatic test_div0();
        int ns, nst;
        run_div(1, 5, 0, -1, -1, 0, ns, nst);
        checks += 4;
        if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_lo: got %h want ffffffff", lo); end
        if (hi !== 5) begin errors++; $display("FAIL div0_hi: got %h want 5", hi); end
        if (ns !== 1) begin errors++; $display("FAIL div0_stall_cycles: got %0d want 1", ns); end
        if (nst !== 0) begin errors++; $display("FAIL div0_start_pulses: got %0d want 0", nst); end
    endtask

    task automatic test_mthi();
        @(negedge clock);
        mthi_we = 1; mt_data = 32'h1234;
        @(negedge clock);
        mthi_we = 0;
        #1;
        checks += 2;
        if (hi !== 32'h1234) begin errors++; $display("FAIL mthi: got %h want 1234", hi); end
        if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mthi_lo_kept: got %h want ffffffff", lo); end
    endtask

    task automatic test_mtlo_wait();
        int ns, nst;
        run_div(0, 50, 5, 10, -1, 0, ns, nst);
        checks += 2;
        if (lo !== 10) begin errors++; $display("FAIL mtlo_wait_lo: got %h want a", lo); end
        if (hi !== 0) begin errors++; $display("FAIL mtlo_wait_hi: got %h want 0", hi); end
    endtask

    task automatic test_reset_mid();
        int ns, nst;
        run_div(0, 1000, 3, -1, 20, 0, ns, nst);
        checks += 3;
        if (hi !== 0) begin errors++; $display("FAIL midreset_hi: got %h want 0", hi); end
        if (lo !== 0) begin errors++; $display("FAIL midreset_lo: got %h want 0", lo); end
        if (stall !== 0) begin errors++; $display("FAIL midreset_stall: got %b want 0", stall); end
        reset = 0;
        run_div(0, 9, 2, -1, -1, 0, ns, nst);
        checks += 2;
        if (lo !== 4) begin errors++; $display("FAIL after_reset_lo: got %h want 4", lo); end
        if (hi !== 1) begin errors++; $display("FAIL after_reset_hi: got %h want 1", hi); end
    endtask

    task automatic test_back_to_back();
        int ns, nst;
        run_div(0, 20, 3, -1, -1, 0, ns, nst);
        checks += 2;
        if (lo !== 6) begin errors++; $display("FAIL b2b_first_lo: got %h want 6", lo); end
        if (hi !== 2) begin errors++; $display("FAIL b2b_first_hi: got %h want 2", hi); end
        run_div(1, 32'hFFFF_FFEB, 32'hFFFF_FFFC, -1, -1, 1, ns, nst);
        checks += 3;
        if (lo !== 5) begin errors++; $display("FAIL b2b_second_lo: got %h want 5", lo); end
        if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL b2b_second_hi: got %h want ffffffff", hi); end
        if (ns !== 35) begin errors++; $display("FAIL b2b_stall_cycles: got %0d want 35", ns); end
    endtask

    initial begin
        test_reset();
        test_divu();
        test_signed();
        test_edges();
        test_div0();
        test_mthi();
        test_mtlo_wait();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
